sw_pe_array: RTL and testbench

Linear systolic array of Smith-Waterman processing elements (PEs) computing affine-gap local-alignment scores.
- Sits directly downstream of the T/V/F pass-through buffer: it consumes the buffer's target character, V (H score) and F stream at PE0.
- It returns the tail PE's character/V/F to that buffer for the next query segment.
- Each PE holds one query character; target characters stream through one PE per cycle.
- The running maximum H is reported as the alignment score.

---
 rtl/sw_pkg.sv | 55 +++++
 rtl/sw_pe.sv | 74 +++++++
 rtl/sw_pe_array.sv | 99 +++++++++
 tb/tb_sw_pe_array.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_pkg
// Brief    : Shared widths, encodings, default scores and saturating helpers
//            for the Smith-Waterman PE array.
// Revision : 1.0 - initial release
// ============================================================================
package sw_pkg;

    localparam int SCORE_W = 12;
    localparam int CHAR_W  = 2;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [CHAR_W-1:0]  char_t;

    typedef enum logic [CHAR_W-1:0] {
        NT_A = 2'd0,
        NT_C = 2'd1,
        NT_G = 2'd2,
        NT_T = 2'd3
    } nt_e;

    localparam int DEF_MATCH    = 2;
    localparam int DEF_MISMATCH = 1;
    localparam int DEF_G_OPEN   = 2;
    localparam int DEF_G_EXT    = 1;

    localparam score_t SCORE_MAX = '1;

    // One column's worth of data travelling from one PE to the next.
    typedef struct packed {
        logic   valid;
        logic   last;
        char_t  t;
        score_t h;
        score_t f;
        score_t m;
    } pe_bus_t;

    function automatic score_t sat_add(input score_t a, input score_t b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    function automatic score_t clamp_sub(input score_t a, input score_t b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic score_t max2(input score_t a, input score_t b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_pe.sv
`default_nettype none
// ============================================================================
// Module   : sw_pe
// Brief    : One affine-gap Smith-Waterman processing element (one query row).
// Revision : 1.0 - initial release
// ============================================================================
module sw_pe
    import sw_pkg::*;
#(
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int G_OPEN   = DEF_G_OPEN,
    parameter int G_EXT    = DEF_G_EXT
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  char_t   q,
    input  pe_bus_t up_bus,
    output pe_bus_t dn_bus
);

    localparam score_t C_MATCH    = score_t'(MATCH);
    localparam score_t C_MISMATCH = score_t'(MISMATCH);
    localparam score_t C_G_OPEN   = score_t'(G_OPEN);
    localparam score_t C_G_EXT    = score_t'(G_EXT);

    score_t  r_diag;
    score_t  r_hp;
    score_t  r_ep;
    pe_bus_t r_dn;

    score_t  w_sd;
    score_t  w_e;
    score_t  w_f;
    score_t  w_h;
    score_t  w_m;

    // Unsigned arithmetic makes the zero floor of H implicit.
    always_comb begin
        w_sd = (q == up_bus.t) ? sat_add(r_diag, C_MATCH)
                               : clamp_sub(r_diag, C_MISMATCH);
        w_e  = max2(clamp_sub(r_hp, C_G_OPEN), clamp_sub(r_ep, C_G_EXT));
        w_f  = max2(clamp_sub(up_bus.h, C_G_OPEN), clamp_sub(up_bus.f, C_G_EXT));
        w_h  = max2(max2(w_sd, w_e), w_f);
        w_m  = max2(up_bus.m, w_h);
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_diag <= '0;
            r_hp   <= '0;
            r_ep   <= '0;
            r_dn   <= '0;
        end else begin
            r_dn.valid <= up_bus.valid;
            // Bubbles leave every piece of recurrence state untouched.
            if (up_bus.valid) begin
                r_dn.last <= up_bus.last;
                r_dn.t    <= up_bus.t;
                r_dn.h    <= w_h;
                r_dn.f    <= w_f;
                r_dn.m    <= w_m;
                r_hp      <= w_h;
                r_ep      <= w_e;
                r_diag    <= up_bus.h;
            end
        end
    end

    assign dn_bus = r_dn;

endmodule
`default_nettype wire

// File: rtl/sw_pe_array.sv
`default_nettype none
// ============================================================================
// Module   : sw_pe_array
// Brief    : Linear systolic chain of sw_pe elements with query shift chain
//            and running global maximum / done generation.
// Revision : 1.0 - initial release
// ============================================================================
module sw_pe_array
    import sw_pkg::*;
#(
    parameter int N_PE     = 128,
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int G_OPEN   = DEF_G_OPEN,
    parameter int G_EXT    = DEF_G_EXT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               q_load,
    input  logic [CHAR_W-1:0]  q_data,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [CHAR_W-1:0]  t_in,
    input  logic [SCORE_W-1:0] V_in,
    input  logic [SCORE_W-1:0] F_in,
    output logic               valid_last,
    output logic [CHAR_W-1:0]  t_last,
    output logic [SCORE_W-1:0] V_last,
    output logic [SCORE_W-1:0] F_last,
    output logic [SCORE_W-1:0] max_score,
    output logic               done
);

    char_t   r_q [N_PE];
    pe_bus_t w_bus [N_PE+1];
    score_t  r_max;
    logic    r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_PE; k++) begin
                r_q[k] <= '0;
            end
        end else if (q_load) begin
            for (int k = 0; k < N_PE-1; k++) begin
                r_q[k] <= r_q[k+1];
            end
            r_q[N_PE-1] <= q_data;
        end
    end

    always_comb begin
        w_bus[0]       = '0;
        w_bus[0].valid = in_valid;
        w_bus[0].last  = in_last;
        w_bus[0].t     = t_in;
        w_bus[0].h     = V_in;
        w_bus[0].f     = F_in;
        w_bus[0].m     = '0;
    end

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
        sw_pe #(
            .MATCH    (MATCH),
            .MISMATCH (MISMATCH),
            .G_OPEN   (G_OPEN),
            .G_EXT    (G_EXT)
        ) u_pe (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .q      (r_q[k]),
            .up_bus (w_bus[k]),
            .dn_bus (w_bus[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_max  <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_bus[N_PE].valid) begin
                r_max <= max2(r_max, w_bus[N_PE].m);
            end
            r_done <= w_bus[N_PE].valid && w_bus[N_PE].last;
        end
    end

    assign valid_last = w_bus[N_PE].valid;
    assign t_last     = w_bus[N_PE].t;
    assign V_last     = w_bus[N_PE].h;
    assign F_last     = w_bus[N_PE].f;
    assign max_score  = r_max;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sw_pe_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_pe_array
// Brief    : Directed self-checking bench for sw_pe_array with N_PE=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_pe_array;

    localparam int N = 4;
    localparam logic [1:0] A = 2'd0, C = 2'd1, G = 2'd2, T = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        q_load = 1'b0;
    logic [1:0]  q_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  t_in = '0;
    logic [11:0] V_in = '0;
    logic [11:0] F_in = '0;
    logic        valid_last;
    logic [1:0]  t_last;
    logic [11:0] V_last;
    logic [11:0] F_last;
    logic [11:0] max_score;
    logic        done;

    int total = 0;
    int bad   = 0;

    sw_pe_array #(.N_PE(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .q_load     (q_load),
        .q_data     (q_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .t_in       (t_in),
        .V_in       (V_in),
        .F_in       (F_in),
        .valid_last (valid_last),
        .t_last     (t_last),
        .V_last     (V_last),
        .F_last     (F_last),
        .max_score  (max_score),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_q(input logic [1:0] c0, input logic [1:0] c1,
                          input logic [1:0] c2, input logic [1:0] c3);
        logic [1:0] chars [4];
        chars = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            q_load = 1'b1;
            q_data = chars[i];
            tick();
        end
        q_load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic col(input logic v, input logic last, input logic [1:0] t);
        in_valid = v;
        in_last  = last;
        t_in     = t;
        V_in     = v ? 12'd0 : 12'hFFF;
        F_in     = v ? 12'd0 : 12'hFFF;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        V_in     = '0;
        F_in     = '0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        check("rst_valid_last", valid_last, 0);
        check("rst_t_last", t_last, 0);
        check("rst_V_last", V_last, 0);
        check("rst_F_last", F_last, 0);
        check("rst_max_score", max_score, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Exact match: query ACGT, target ACGT
        load_q(A, C, G, T);
        pulse_start();
        col(1, 0, A);
        col(1, 0, C);
        col(1, 0, G);
        col(1, 1, T);
        tick(); tick(); tick();
        check("exact_valid_last", valid_last, 1);
        check("exact_t_last", t_last, T);
        check("exact_V_last", V_last, 8);
        check("exact_F_last", F_last, 2);
        check("exact_done_early", done, 0);
        tick();
        check("exact_done", done, 1);
        check("exact_max", max_score, 8);
        tick();
        check("exact_done_once", done, 0);

        // All-mismatch: query AAAA, target CCCC
        load_q(A, A, A, A);
        pulse_start();
        col(1, 0, C); check("mm_V_last_1", V_last, 0);
        col(1, 0, C); check("mm_V_last_2", V_last, 0);
        col(1, 0, C); check("mm_V_last_3", V_last, 0);
        col(1, 1, C); check("mm_V_last_4", V_last, 0);
        tick(); check("mm_V_last_5", V_last, 0);
        tick(); check("mm_V_last_6", V_last, 0);
        tick(); check("mm_V_last_7", V_last, 0);
        check("mm_valid_tail", valid_last, 1);
        tick();
        check("mm_done", done, 1);
        check("mm_max", max_score, 0);

        // Mismatch inside the alignment: query ACGT, target ACTT
        load_q(A, C, G, T);
        pulse_start();
        col(1, 0, A);
        col(1, 0, C);
        col(1, 0, T);
        col(1, 1, T);
        tick(); tick(); tick(); tick();
        check("inner_done", done, 1);
        check("inner_max", max_score, 5);

        // Bubbles on alternate cycles, with garbage on the bubble inputs
        pulse_start();
        col(1, 0, A);
        col(0, 1, T);
        col(1, 0, C);
        col(0, 1, A);
        col(1, 0, G);
        col(0, 1, C);
        col(1, 1, T);
        tick(); tick(); tick();
        check("bub_done_early", done, 0);
        tick();
        check("bub_done", done, 1);
        check("bub_max", max_score, 8);

        // Start in the cycle after done, coincident with a valid last column
        start    = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        t_in     = T;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("drop_max_cleared", max_score, 0);
        for (int i = 0; i < N + 2; i++) begin
            check("drop_valid_last", valid_last, 0);
            check("drop_done", done, 0);
            tick();
        end

        // Restart: target TTTT against query ACGT
        col(1, 0, T);
        col(1, 0, T);
        col(1, 0, T);
        col(1, 1, T);
        tick(); tick(); tick(); tick();
        check("restart_done", done, 1);
        check("restart_max", max_score, 2);

        // Reset two cycles into a new stream (no start, so max_score is nonzero)
        col(1, 0, A);
        col(1, 0, C);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        t_in     = G;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("midrst_valid_last", valid_last, 0);
        check("midrst_t_last", t_last, 0);
        check("midrst_V_last", V_last, 0);
        check("midrst_F_last", F_last, 0);
        check("midrst_max", max_score, 0);
        check("midrst_done", done, 0);
        for (int i = 0; i < N + 2; i++) begin
            tick();
            check("midrst_no_done", done, 0);
            check("midrst_no_valid", valid_last, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
